// File: rtl/spi_flash_xip_reader_pkg.sv
// Shared types and constants for the SPI NOR flash word-read engine.
package spi_flash_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP,
    RESP
  } state_t;

  localparam logic [7:0]  CMD_READ      = 8'h03;
  localparam int unsigned FRAME_BITS    = 64;
  localparam int unsigned CMD_ADDR_BITS = 32;

  // Flash streams the lowest byte address first; the bus expects it in the low lane.
  function automatic logic [31:0] bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/spi_flash_xip_reader_sck_gen.sv
// Serial clock divider: sck toggles every DIV enabled cycles, with strobes
// marking the cycle whose edge performs a rising or falling toggle.
module spi_sck_gen #(
  parameter int unsigned DIV = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  output logic sck,
  output logic rise,
  output logic fall
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] div_cnt;
  logic          wrap;

  assign wrap = enable && (div_cnt == CW'(DIV - 1));
  assign rise = wrap && !sck;
  assign fall = wrap && sck;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
      sck     <= 1'b0;
    end else if (!enable) begin
      div_cnt <= '0;
      sck     <= 1'b0;
    end else if (wrap) begin
      div_cnt <= '0;
      sck     <= !sck;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_flash_xip_reader.sv
// SPI mode-0 read engine: sends cmd 0x03 + 24-bit address, clocks in one
// 32-bit word and returns it byte-swapped on a valid/ready response port.
module spi_flash_xip_reader #(
  parameter int unsigned DIV     = 1,
  parameter int unsigned SS_IDLE = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [23:0] req_addr,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic        spi_sck,
  output logic        spi_ss,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  import spi_flash_pkg::*;

  localparam int unsigned GW = $clog2(SS_IDLE + 1);

  state_t          state, state_nxt;
  logic [30:0]     tx;
  logic [31:0]     rx;
  logic [6:0]      bit_cnt;
  logic [GW-1:0]   gap_cnt;
  logic            sck_rise, sck_fall;

  spi_sck_gen #(.DIV(DIV)) u_sck_gen (
    .clock  (clock),
    .reset  (reset),
    .enable (state == SHIFT),
    .sck    (spi_sck),
    .rise   (sck_rise),
    .fall   (sck_fall)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = SHIFT;
      end
      SHIFT:   if (sck_fall && bit_cnt == 7'(FRAME_BITS)) state_nxt = GAP;
      GAP:     if (gap_cnt == GW'(SS_IDLE)) state_nxt = RESP;
      RESP:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // tx holds only the bits not yet on the wire: the MSB of {cmd,addr} goes
  // straight to spi_mosi at accept, the remaining 31 are shifted out on falls.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tx         <= '0;
      rx         <= '0;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      spi_ss     <= 1'b1;
      spi_mosi   <= 1'b0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            tx       <= {CMD_READ[6:0], req_addr};
            spi_mosi <= CMD_READ[7];
            spi_ss   <= 1'b0;
            bit_cnt  <= '0;
          end
        end
        SHIFT: begin
          if (sck_rise) begin
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt >= 7'(CMD_ADDR_BITS)) rx <= {rx[30:0], spi_miso};
          end
          if (sck_fall) begin
            if (bit_cnt == 7'(FRAME_BITS)) begin
              spi_ss   <= 1'b1;
              spi_mosi <= 1'b0;
              gap_cnt  <= '0;
            end else if (bit_cnt < 7'(CMD_ADDR_BITS)) begin
              spi_mosi <= tx[30];
              tx       <= {tx[29:0], 1'b0};
            end else begin
              spi_mosi <= 1'b0;
            end
          end
        end
        GAP: begin
          gap_cnt <= gap_cnt + 1'b1;
          if (gap_cnt == GW'(SS_IDLE)) begin
            resp_data  <= bswap32(rx);
            resp_valid <= 1'b1;
          end
        end
        RESP: begin
          if (resp_ready) resp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_flash_xip_reader.sv
// Directed bench: two engines (DIV=1/SS_IDLE=1 and DIV=4/SS_IDLE=3) share one
// behavioural flash model through a select mux; a monitor checks every frame.
module tb_spi_flash_xip_reader;

  localparam int D1 = 1, S1 = 1, D2 = 4, S2 = 3;
  localparam int LIM = 2000;

  logic        clock = 1'b0, reset = 1'b1, sel = 1'b0;
  logic        req_valid = 1'b0, resp_ready = 1'b0, spi_miso = 1'b0;
  logic [23:0] req_addr = '0, exp_addr = '0;

  logic        rr1, rv1, sck1, ss1, mo1, rr2, rv2, sck2, ss2, mo2;
  logic [31:0] rd1, rd2;
  logic        req_ready_m, resp_valid_m, spi_sck_m, spi_ss_m, spi_mosi_m;
  logic [31:0] resp_data_m;

  int n_cmp = 0, n_fail = 0, cyc = 0;
  int f_cnt = 0, dphase_viol = 0, mosi_viol = 0, half_viol = 0, idle_sck_edges = 0;
  int run_len = 0, t_rise = 0, last_gap = 0;
  logic [31:0] f_sr = '0;
  logic in_frame = 1'b0, abort = 1'b0, prev_sck = 1'b0, prev_ss = 1'b1, prev_mosi = 1'b0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  spi_flash_xip_reader #(.DIV(D1), .SS_IDLE(S1)) u_dut1 (
    .clock(clock), .reset(reset), .req_valid(req_valid & ~sel), .req_ready(rr1),
    .req_addr(req_addr), .resp_valid(rv1), .resp_ready(resp_ready & ~sel),
    .resp_data(rd1), .spi_sck(sck1), .spi_ss(ss1), .spi_mosi(mo1), .spi_miso(spi_miso));

  spi_flash_xip_reader #(.DIV(D2), .SS_IDLE(S2)) u_dut2 (
    .clock(clock), .reset(reset), .req_valid(req_valid & sel), .req_ready(rr2),
    .req_addr(req_addr), .resp_valid(rv2), .resp_ready(resp_ready & sel),
    .resp_data(rd2), .spi_sck(sck2), .spi_ss(ss2), .spi_mosi(mo2), .spi_miso(spi_miso));

  assign req_ready_m  = sel ? rr2  : rr1;
  assign resp_valid_m = sel ? rv2  : rv1;
  assign resp_data_m  = sel ? rd2  : rd1;
  assign spi_sck_m    = sel ? sck2 : sck1;
  assign spi_ss_m     = sel ? ss2  : ss1;
  assign spi_mosi_m   = sel ? mo2  : mo1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Flash contents: a fixed word at 0x100, elsewhere a simple address hash.
  function automatic logic [7:0] fbyte(input logic [23:0] a);
    case (a)
      24'h000100: return 8'hEF;
      24'h000101: return 8'hBE;
      24'h000102: return 8'hAD;
      24'h000103: return 8'hDE;
      default:    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h3C;
    endcase
  endfunction

  // Behavioural flash: samples mosi on rising sck, drives miso on falling sck.
  always @(negedge spi_ss_m) begin
    f_cnt = 0; f_sr = '0; in_frame = 1'b1;
  end

  always @(posedge spi_sck_m) begin
    if (f_cnt >= 32 && spi_mosi_m !== 1'b0) dphase_viol++;
    if (f_cnt < 32) f_sr = {f_sr[30:0], spi_mosi_m};
    f_cnt++;
  end

  always @(negedge spi_sck_m) begin
    int idx;
    logic [7:0] b;
    if (f_cnt >= 32 && f_cnt < 64) begin
      idx = f_cnt - 32;
      b = fbyte(f_sr[23:0] + 24'(idx / 8));
      spi_miso = b[7 - (idx % 8)];
    end
  end

  always @(posedge spi_ss_m) begin
    if (in_frame) begin
      in_frame = 1'b0;
      if (!abort) begin
        check("frame_rises", f_cnt, 64);
        check("frame_cmd", {24'h0, f_sr[31:24]}, 32'h03);
        check("frame_addr", {8'h0, f_sr[23:0]}, {8'h0, exp_addr});
      end
    end
  end

  always @(negedge clock) begin
    if (prev_ss && !spi_ss_m) begin
      run_len = 1;
      last_gap = cyc - t_rise;
    end else if (spi_sck_m != prev_sck) begin
      if (run_len != (sel ? D2 : D1) && !abort) half_viol++;
      run_len = 1;
    end else begin
      run_len++;
    end
    if (!prev_ss && spi_ss_m) t_rise = cyc;
    if (!prev_sck && spi_sck_m && spi_mosi_m != prev_mosi) mosi_viol++;
    if (prev_ss && spi_ss_m && spi_sck_m != prev_sck) idle_sck_edges++;
    prev_sck = spi_sck_m; prev_ss = spi_ss_m; prev_mosi = spi_mosi_m;
  end

  task automatic read_word(input logic [23:0] addr, input int hold, input bit keep,
                           output logic [31:0] data, output int t_ss, output int t_rv);
    int k, viol;
    req_addr = addr; exp_addr = addr; req_valid = 1'b1;
    k = 0;
    while (!req_ready_m && k < LIM) begin @(negedge clock); k++; end
    check("accept_wait", 32'(k < LIM), 1);
    @(posedge clock); #1;
    if (!keep) req_valid = 1'b0;
    t_ss = 0;
    while (!spi_ss_m && t_ss < LIM) begin @(posedge clock); #1; t_ss++; end
    t_rv = 0;
    while (!resp_valid_m && t_rv < LIM) begin @(posedge clock); #1; t_rv++; end
    @(negedge clock);
    data = resp_data_m; viol = 0;
    for (int i = 0; i < hold; i++) begin
      if (!resp_valid_m || resp_data_m !== data || req_ready_m || !spi_ss_m || spi_sck_m) viol++;
      @(negedge clock);
    end
    if (hold > 0) check("hold_stable", viol, 0);
    resp_ready = 1'b1;
    @(posedge clock); #1;
    resp_ready = 1'b0;
    check("resp_clear", {31'h0, resp_valid_m}, 0);
  endtask

  typedef struct {
    logic        sel;
    logic [23:0] addr;
    int          hold;
    logic [31:0] exp_word;
  } vec_t;

  initial begin
    vec_t tbl[6];
    logic [31:0] w;
    logic [23:0] a;
    int ts, tr, k;

    tbl[0] = '{1'b0, 24'h000100, 0,  32'hDEADBEEF};
    tbl[1] = '{1'b0, 24'h000100, 10, 32'hDEADBEEF};
    tbl[2] = '{1'b0, 24'hABCDEF, 2,  32'hA8ABAAB5};
    tbl[3] = '{1'b0, 24'h000101, 0,  32'h39DEADBE};
    tbl[4] = '{1'b1, 24'h123456, 0,  32'h43424D4C};
    tbl[5] = '{1'b1, 24'hFFFFFC, 3,  32'hC3C2C1C0};

    repeat (3) @(negedge clock);
    check("rst_ss",    {31'h0, ss1}, 1);
    check("rst_sck",   {31'h0, sck1}, 0);
    check("rst_mosi",  {31'h0, mo1}, 0);
    check("rst_ready", {31'h0, rr1}, 1);
    check("rst_valid", {31'h0, rv1}, 0);
    check("rst_data",  rd1, 0);
    check("rst_ss2",   {31'h0, ss2}, 1);
    check("rst_sck2",  {31'h0, sck2}, 0);
    reset = 1'b0;
    @(negedge clock);

    for (int i = 0; i < 6; i++) begin
      sel = tbl[i].sel;
      read_word(tbl[i].addr, tbl[i].hold, 1'b0, w, ts, tr);
      check($sformatf("vec%0d_data", i), w, tbl[i].exp_word);
      check($sformatf("vec%0d_ss_lat", i), ts, tbl[i].sel ? 128 * D2 : 128 * D1);
      check($sformatf("vec%0d_rv_lat", i), tr, tbl[i].sel ? S2 + 1 : S1 + 1);
    end

    // Back-to-back with req_valid held across both requests.
    sel = 1'b0;
    read_word(24'h000000, 0, 1'b1, w, ts, tr);
    check("b2b_first", w, 32'h3F3E3D3C);
    read_word(24'hFFFFFC, 0, 1'b0, w, ts, tr);
    check("b2b_second", w, 32'hC3C2C1C0);
    check("b2b_gap_ok", 32'(last_gap >= S1 + 1), 1);

    // Reset after the 20th rising sck edge of a frame.
    req_addr = 24'h000050; exp_addr = 24'h000050; req_valid = 1'b1;
    k = 0;
    while (f_cnt != 20 && k < LIM) begin @(posedge clock); #2; k++; end
    check("abort_reach20", f_cnt, 20);
    req_valid = 1'b0; abort = 1'b1; reset = 1'b1;
    #1;
    check("abort_ss",    {31'h0, ss1}, 1);
    check("abort_sck",   {31'h0, sck1}, 0);
    check("abort_valid", {31'h0, rv1}, 0);
    check("abort_ready", {31'h0, rr1}, 1);
    @(negedge clock); reset = 1'b0;
    k = 0;
    for (int i = 0; i < 5; i++) begin @(negedge clock); k += int'(rv1); end
    check("abort_no_resp", k, 0);
    abort = 1'b0;
    read_word(24'h000200, 0, 1'b0, w, ts, tr);
    check("post_abort_data", w, 32'h3D3C3F3E);

    // Random addresses, alternating engines; the frame monitor checks protocol.
    for (int i = 0; i < 4; i++) begin
      sel = i[0];
      a = 24'($urandom);
      read_word(a, 0, 1'b0, w, ts, tr);
      check($sformatf("rand%0d_data", i), w,
            {fbyte(a + 24'd3), fbyte(a + 24'd2), fbyte(a + 24'd1), fbyte(a)});
    end

    repeat (4) @(negedge clock);
    check("mosi_stable_at_rise", mosi_viol, 0);
    check("mosi_zero_data_phase", dphase_viol, 0);
    check("sck_half_period", half_viol, 0);
    check("no_sck_while_ss_high", idle_sck_edges, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
